// File: rtl/ad1_pkg.sv
// Shared types and frame geometry for the dual-channel PmodAD1 (AD7476A) controller.
package ad1_pkg;

   localparam int SAMPLE_W   = 12;
   localparam int FRAME_BITS = 16;
   localparam int LEAD_BITS  = 4;
   localparam int BIT_CNT_W  = 4;
   localparam int QUIET_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_QUIET = 2'd2
   } state_t;

   // The converter always sends leading zeros; anything else means a corrupted frame.
   function automatic logic lead_err(input logic [FRAME_BITS-1:0] frame1,
                                     input logic [FRAME_BITS-1:0] frame2);
      return (|frame1[FRAME_BITS-1 -: LEAD_BITS]) | (|frame2[FRAME_BITS-1 -: LEAD_BITS]);
   endfunction

endpackage

// File: rtl/ad1_sclk_gen.sv
// SCLK divider: registered serial clock that idles high, plus strobes flagging the
// CLK edge on which SCLK is about to rise or fall.
module ad1_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             wrap;

   assign wrap = enable && !clear && (div_cnt == DIV_LAST);
   assign rise = wrap && !sclk;
   assign fall = wrap && sclk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         sclk    <= 1'b1;
      end else if (clear || !enable) begin
         div_cnt <= '0;
         sclk    <= 1'b1;
      end else if (wrap) begin
         div_cnt <= '0;
         sclk    <= ~sclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pmod_ad1_ctrl.sv
// Frame controller for two AD7476A converters sharing CS and SCLK: runs 16-bit frames,
// captures the 12-bit samples and flags frames whose leading bits are not zero.
module pmod_ad1_ctrl
   import ad1_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int QUIET_CYCLES = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                continuous,
   input  logic                sdata1,
   input  logic                sdata2,
   output logic                sclk,
   output logic                cs,
   output logic [SAMPLE_W-1:0] data1,
   output logic [SAMPLE_W-1:0] data2,
   output logic                valid,
   output logic                frame_err,
   output logic                busy
);

   localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);

   state_t                  state;
   logic                    entry;
   logic                    last_bit;
   logic [BIT_CNT_W-1:0]    bit_cnt;
   logic [QUIET_W-1:0]      quiet_cnt;
   logic [FRAME_BITS-1:0]   shift1;
   logic [FRAME_BITS-1:0]   shift2;
   logic [FRAME_BITS-1:0]   next1;
   logic [FRAME_BITS-1:0]   next2;
   logic                    sclk_rise;
   logic                    sclk_fall;
   logic                    quiet_done;
   logic                    launch;

   // The entry pulse holds the divider cleared for one cycle, so the first SCLK
   // fall lands 1+CLK_DIV cycles after the launching edge.
   ad1_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (state == ST_CONV),
      .clear  (entry),
      .sclk   (sclk),
      .rise   (sclk_rise),
      .fall   (sclk_fall)
   );

   assign next1      = {shift1[FRAME_BITS-2:0], sdata1};
   assign next2      = {shift2[FRAME_BITS-2:0], sdata2};
   assign quiet_done = (state == ST_QUIET) && (quiet_cnt == QUIET_LAST);
   assign launch     = ((state == ST_IDLE) || quiet_done) && (start || continuous);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cs        <= 1'b1;
         busy      <= 1'b0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         data1     <= '0;
         data2     <= '0;
         entry     <= 1'b0;
         last_bit  <= 1'b0;
         bit_cnt   <= '0;
         quiet_cnt <= '0;
         shift1    <= '0;
         shift2    <= '0;
      end else begin
         valid <= 1'b0;
         entry <= 1'b0;
         if (launch) begin
            state    <= ST_CONV;
            cs       <= 1'b0;
            busy     <= 1'b1;
            entry    <= 1'b1;
            last_bit <= 1'b0;
            bit_cnt  <= '0;
            shift1   <= '0;
            shift2   <= '0;
         end else begin
            unique case (state)
               ST_CONV: begin
                  // Falls are counted; the rise after the 16th fall closes the frame.
                  if (sclk_fall) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == '1) last_bit <= 1'b1;
                  end
                  if (sclk_rise) begin
                     shift1 <= next1;
                     shift2 <= next2;
                     if (last_bit) begin
                        state     <= ST_QUIET;
                        cs        <= 1'b1;
                        quiet_cnt <= '0;
                        valid     <= 1'b1;
                        data1     <= next1[SAMPLE_W-1:0];
                        data2     <= next2[SAMPLE_W-1:0];
                        frame_err <= lead_err(next1, next2);
                     end
                  end
               end
               ST_QUIET: begin
                  if (quiet_done) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     quiet_cnt <= quiet_cnt + 1'b1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pmod_ad1_ctrl.sv
// Bench for pmod_ad1_ctrl: two instances (CLK_DIV 4 and 2) driven by behavioural
// converter models that shift queued 16-bit words out MSB-first after each SCLK fall.
module tb_pmod_ad1_ctrl;

   localparam int DIV_A = 4;
   localparam int DIV_B = 2;
   localparam int QUIET = 8;
   localparam int LAT_A = 1 + 32 * DIV_A;
   localparam int LAT_B = 1 + 32 * DIV_B;

   logic clk = 1'b0;
   logic rst_n;

   logic        start_a, cont_a, sdata1_a, sdata2_a, sclk_a, cs_a, valid_a, frame_err_a, busy_a;
   logic [11:0] data1_a, data2_a;
   logic        start_b, cont_b, sdata1_b, sdata2_b, sclk_b, cs_b, valid_b, frame_err_b, busy_b;
   logic [11:0] data1_b, data2_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pmod_ad1_ctrl #(.CLK_DIV(DIV_A), .QUIET_CYCLES(QUIET)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a),
      .sdata1(sdata1_a), .sdata2(sdata2_a), .sclk(sclk_a), .cs(cs_a),
      .data1(data1_a), .data2(data2_a), .valid(valid_a), .frame_err(frame_err_a), .busy(busy_a));

   pmod_ad1_ctrl #(.CLK_DIV(DIV_B), .QUIET_CYCLES(QUIET)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b),
      .sdata1(sdata1_b), .sdata2(sdata2_b), .sclk(sclk_b), .cs(cs_b),
      .data1(data1_b), .data2(data2_b), .valid(valid_b), .frame_err(frame_err_b), .busy(busy_b));

   // Converter model A: a new word per CS fall, bit (16-n) presented after the n-th SCLK fall.
   logic [15:0] q1[$];
   logic [15:0] q2[$];
   logic [15:0] w1a = '0, w2a = '0;
   int          fc_a = 0;
   logic        pcs_a = 1'b1, psclk_a = 1'b1;

   always @(posedge clk) begin
      #1;
      if (pcs_a === 1'b1 && cs_a === 1'b0) begin
         fc_a = 0;
         if (q1.size() > 0) w1a = q1.pop_front(); else w1a = 16'h0;
         if (q2.size() > 0) w2a = q2.pop_front(); else w2a = 16'h0;
      end else if (psclk_a === 1'b1 && sclk_a === 1'b0 && cs_a === 1'b0) begin
         fc_a = fc_a + 1;
      end
      pcs_a   = cs_a;
      psclk_a = sclk_a;
   end

   always_comb begin
      sdata1_a = 1'b0;
      sdata2_a = 1'b0;
      if (fc_a >= 1 && fc_a <= 16) begin
         sdata1_a = w1a[4'(16 - fc_a)];
         sdata2_a = w2a[4'(16 - fc_a)];
      end
   end

   // Converter model B: fixed words set directly by the test.
   logic [15:0] w1b = '0, w2b = '0;
   int          fc_b = 0;
   logic        pcs_b = 1'b1, psclk_b = 1'b1;

   always @(posedge clk) begin
      #1;
      if (pcs_b === 1'b1 && cs_b === 1'b0) fc_b = 0;
      else if (psclk_b === 1'b1 && sclk_b === 1'b0 && cs_b === 1'b0) fc_b = fc_b + 1;
      pcs_b   = cs_b;
      psclk_b = sclk_b;
   end

   always_comb begin
      sdata1_b = 1'b0;
      sdata2_b = 1'b0;
      if (fc_b >= 1 && fc_b <= 16) begin
         sdata1_b = w1b[4'(16 - fc_b)];
         sdata2_b = w2b[4'(16 - fc_b)];
      end
   end

   // One START-launched frame on instance A, measured from the launching edge.
   task automatic frame_a(input int budget, output int lat, output int cs_low, output int falls);
      logic prev;
      lat = -1; cs_low = 0; falls = 0;
      repeat (QUIET + 4) @(posedge clk);
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      prev = sclk_a;
      for (int n = 1; n <= budget; n++) begin
         @(posedge clk); #1;
         if (cs_a === 1'b0) cs_low++;
         if (prev === 1'b1 && sclk_a === 1'b0) falls++;
         prev = sclk_a;
         if (valid_a === 1'b1) begin lat = n; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_a = 1'b0; cont_a = 1'b0; start_b = 1'b0; cont_b = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++; if ({cs_a, sclk_a, busy_a, valid_a, frame_err_a} !== 5'b11000) begin
         errors++; $display("FAIL reset_ctrl got %b want 11000", {cs_a, sclk_a, busy_a, valid_a, frame_err_a}); end
      checks++; if (data1_a !== 12'h0 || data2_a !== 12'h0) begin
         errors++; $display("FAIL reset_data got %h/%h want 000/000", data1_a, data2_a); end
      checks++; if ({cs_b, sclk_b, busy_b, valid_b} !== 4'b1100) begin
         errors++; $display("FAIL reset_b got %b want 1100", {cs_b, sclk_b, busy_b, valid_b}); end
      @(negedge clk); rst_n = 1'b1;
      repeat (20) @(posedge clk); #1;
      checks++; if (cs_a !== 1'b1 || busy_a !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset cs=%b busy=%b want 1/0", cs_a, busy_a); end
   endtask

   task automatic test_single();
      int lat, csl, fl;
      q1.push_back(16'h0ABC); q2.push_back(16'h0123);
      frame_a(LAT_A + 20, lat, csl, fl);
      checks++; if (lat != LAT_A) begin errors++; $display("FAIL single_latency got %0d want %0d", lat, LAT_A); end
      checks++; if (data1_a !== 12'hABC) begin errors++; $display("FAIL single_data1 got %h want abc", data1_a); end
      checks++; if (data2_a !== 12'h123) begin errors++; $display("FAIL single_data2 got %h want 123", data2_a); end
      checks++; if (frame_err_a !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", frame_err_a); end
      checks++; if (csl != 32 * DIV_A) begin errors++; $display("FAIL single_cs_low got %0d want %0d", csl, 32 * DIV_A); end
      checks++; if (fl != 16) begin errors++; $display("FAIL single_falls got %0d want 16", fl); end
      @(posedge clk); #1;
      checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL single_valid_pulse got %b want 0", valid_a); end
   endtask

   task automatic test_continuous();
      int t[3];
      int nv = 0, cs_hi = 0;
      logic [15:0] e1[3], e2[3];
      repeat (QUIET + 4) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         e1[i] = 16'(i + 1);
         e2[i] = {4'h0, 12'($urandom)};
         q1.push_back(e1[i]); q2.push_back(e2[i]);
      end
      t[0] = -1; t[1] = -1; t[2] = -1;
      @(negedge clk); cont_a = 1'b1;
      @(posedge clk); #1;
      for (int n = 1; n <= 3 * (LAT_A + QUIET) + 30; n++) begin
         @(posedge clk); #1;
         if (valid_a === 1'b1) begin
            if (nv < 3) begin
               t[nv] = n;
               checks++; if (data1_a !== e1[nv][11:0] || data2_a !== e2[nv][11:0]) begin
                  errors++; $display("FAIL cont_data%0d got %h/%h want %h/%h", nv, data1_a, data2_a, e1[nv][11:0], e2[nv][11:0]); end
            end
            nv++;
         end
         if (nv == 1 && cs_a === 1'b1) cs_hi++;
         if (nv == 2 && n == t[1] + QUIET + 5) cont_a = 1'b0;
      end
      cont_a = 1'b0;
      checks++; if (nv != 3) begin errors++; $display("FAIL cont_count got %0d want 3", nv); end
      checks++; if (t[0] != LAT_A) begin errors++; $display("FAIL cont_first got %0d want %0d", t[0], LAT_A); end
      checks++; if (t[1] - t[0] != LAT_A + QUIET || t[2] - t[1] != LAT_A + QUIET) begin
         errors++; $display("FAIL cont_spacing got %0d,%0d want %0d", t[1] - t[0], t[2] - t[1], LAT_A + QUIET); end
      checks++; if (cs_hi != QUIET) begin errors++; $display("FAIL cont_cs_high got %0d want %0d", cs_hi, QUIET); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL cont_idle busy=%b want 0", busy_a); end
   endtask

   task automatic test_frame_err();
      int lat, csl, fl;
      logic [15:0] c1, c2;
      q1.push_back(16'h0555); q2.push_back(16'h8FFF);
      frame_a(LAT_A + 20, lat, csl, fl);
      checks++; if (data2_a !== 12'hFFF || data1_a !== 12'h555) begin
         errors++; $display("FAIL err_data got %h/%h want 555/fff", data1_a, data2_a); end
      checks++; if (frame_err_a !== 1'b1) begin errors++; $display("FAIL err_flag got %b want 1", frame_err_a); end
      repeat (5) @(posedge clk); #1;
      checks++; if (frame_err_a !== 1'b1) begin errors++; $display("FAIL err_held got %b want 1", frame_err_a); end
      c1 = {4'h0, 12'($urandom)}; c2 = {4'h0, 12'($urandom)};
      q1.push_back(c1); q2.push_back(c2);
      frame_a(LAT_A + 20, lat, csl, fl);
      checks++; if (frame_err_a !== 1'b0 || data1_a !== c1[11:0] || data2_a !== c2[11:0]) begin
         errors++; $display("FAIL err_clear got %b %h/%h want 0 %h/%h", frame_err_a, data1_a, data2_a, c1[11:0], c2[11:0]); end
   endtask

   task automatic test_start_busy();
      int nv = 0, tv = -1;
      logic [15:0] c1, c2;
      c1 = {4'h0, 12'($urandom)}; c2 = {4'h0, 12'($urandom)};
      q1.push_back(c1); q2.push_back(c2);
      repeat (QUIET + 4) @(posedge clk);
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      for (int n = 1; n <= LAT_A + QUIET + 60; n++) begin
         @(posedge clk); #1;
         start_a = (n == 9 || n == 59);
         if (valid_a === 1'b1) begin nv++; tv = n; end
      end
      start_a = 1'b0;
      checks++; if (nv != 1 || tv != LAT_A) begin errors++; $display("FAIL busy_start got %0d valids at %0d want 1 at %0d", nv, tv, LAT_A); end
      checks++; if (busy_a !== 1'b0 || cs_a !== 1'b1) begin errors++; $display("FAIL busy_idle got busy=%b cs=%b want 0/1", busy_a, cs_a); end
      checks++; if (data1_a !== c1[11:0] || data2_a !== c2[11:0]) begin
         errors++; $display("FAIL busy_data got %h/%h want %h/%h", data1_a, data2_a, c1[11:0], c2[11:0]); end
   endtask

   task automatic test_reset_mid();
      int nv = 0, cs_lo = 0, lat, csl, fl;
      logic [15:0] c1, c2;
      q1.push_back(16'h0FA5); q2.push_back(16'h05AF);
      repeat (QUIET + 4) @(posedge clk);
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      for (int n = 1; n <= 70; n++) begin
         @(posedge clk); #1;
         if (valid_a === 1'b1) nv++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (cs_a !== 1'b1 || sclk_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
         errors++; $display("FAIL rst_mid_ctrl got cs=%b sclk=%b valid=%b busy=%b want 1/1/0/0", cs_a, sclk_a, valid_a, busy_a); end
      checks++; if (data1_a !== 12'h0 || data2_a !== 12'h0) begin
         errors++; $display("FAIL rst_mid_data got %h/%h want 000/000", data1_a, data2_a); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 150; n++) begin
         @(posedge clk); #1;
         if (valid_a === 1'b1) nv++;
         if (cs_a !== 1'b1) cs_lo++;
      end
      checks++; if (nv != 0 || cs_lo != 0) begin errors++; $display("FAIL rst_mid_quiet got valids=%0d cs_low=%0d want 0/0", nv, cs_lo); end
      c1 = {4'h0, 12'($urandom)}; c2 = {4'h0, 12'($urandom)};
      q1.push_back(c1); q2.push_back(c2);
      frame_a(LAT_A + 20, lat, csl, fl);
      checks++; if (lat != LAT_A || data1_a !== c1[11:0] || data2_a !== c2[11:0]) begin
         errors++; $display("FAIL rst_mid_next got lat=%0d %h/%h want %0d %h/%h", lat, data1_a, data2_a, LAT_A, c1[11:0], c2[11:0]); end
   endtask

   task automatic test_random();
      int lat, csl, fl;
      logic [15:0] r1, r2;
      logic exp_err;
      for (int i = 0; i < 6; i++) begin
         r1 = 16'($urandom); r2 = 16'($urandom);
         if ($urandom_range(0, 1) == 0) begin r1[15:12] = 4'h0; r2[15:12] = 4'h0; end
         exp_err = (r1 >= 16'h1000) || (r2 >= 16'h1000);
         q1.push_back(r1); q2.push_back(r2);
         frame_a(LAT_A + 20, lat, csl, fl);
         checks++; if (lat != LAT_A || data1_a !== r1[11:0] || data2_a !== r2[11:0] || frame_err_a !== exp_err) begin
            errors++; $display("FAIL random%0d got lat=%0d %h/%h err=%b want %0d %h/%h err=%b",
                               i, lat, data1_a, data2_a, frame_err_a, LAT_A, r1[11:0], r2[11:0], exp_err); end
      end
   endtask

   task automatic test_div2();
      int lat = -1, falls = 0;
      logic prev;
      w1b = 16'h0FFF; w2b = {4'h0, 12'($urandom)};
      @(negedge clk); start_b = 1'b1;
      @(posedge clk); #1; start_b = 1'b0;
      prev = sclk_b;
      for (int n = 1; n <= LAT_B + 20; n++) begin
         @(posedge clk); #1;
         if (prev === 1'b1 && sclk_b === 1'b0) falls++;
         prev = sclk_b;
         if (valid_b === 1'b1) begin lat = n; break; end
      end
      checks++; if (lat != LAT_B) begin errors++; $display("FAIL div2_latency got %0d want %0d", lat, LAT_B); end
      checks++; if (data1_b !== 12'hFFF || data2_b !== w2b[11:0] || frame_err_b !== 1'b0) begin
         errors++; $display("FAIL div2_data got %h/%h err=%b want fff/%h err=0", data1_b, data2_b, frame_err_b, w2b[11:0]); end
      checks++; if (falls != 16) begin errors++; $display("FAIL div2_falls got %0d want 16", falls); end
      repeat (QUIET + 4) @(posedge clk); #1;
      checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL div2_idle busy=%b want 0", busy_b); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_continuous();
      test_frame_err();
      test_start_busy();
      test_reset_mid();
      test_random();
      test_div2();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pmod_ad1_ctrl.md
PMOD_AD1_CTRL -- requirements
Module: pmod_ad1_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: CLK cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have parameter QUIET_CYCLES, default 8: CLK cycles CS is held high between frames; legal range 1..255.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  system clock; every flop is on its rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 START  input  1  request one dual-channel conversion; level-sampled in IDLE.
REQ-007 CONTINUOUS  input  1  when high, chain frames back-to-back with no START.
REQ-008 SDATA1  input  1  serial data from converter channel 1.
REQ-009 SDATA2  input  1  serial data from converter channel 2.
REQ-010 SCLK  output  1  serial clock to converters; idles high.
REQ-011 CS  output  1  active-low chip select shared by both converters.
REQ-012 DATA1  output  12  last channel-1 sample.
REQ-013 DATA2  output  12  last channel-2 sample.
REQ-014 VALID  output  1  one-CLK pulse when DATA1/DATA2 update.
REQ-015 FRAME_ERR  output  1  high with VALID when any leading bit was nonzero; held until next VALID.
REQ-016 BUSY  output  1  high in CONV and QUIET.

Function
REQ-017 SHALL implement FSM IDLE -> CONV -> QUIET -> IDLE|CONV.
- Encoding is free.
REQ-018 IDLE SHALL drive CS=1, SCLK=1, BUSY=0.
- START=1 or CONTINUOUS=1 -> CONV on next edge.
REQ-019 CONV entry SHALL:
- drive CS=0;
- clear the divider counter (0..CLK_DIV-1) and the 4-bit bit counter.
REQ-020 In CONV, SCLK SHALL toggle on each divider wrap, first toggle falling.
- Frame = exactly 16 SCLK periods.
- With START sampled at edge 0, falling edges occur at 1+(2k+1)*CLK_DIV; rising edges at 1+(2k+2)*CLK_DIV, k=0..15.
REQ-021 SDATA1/SDATA2 SHALL be shifted MSB-first into 16-bit registers on every CLK edge where SCLK goes 0->1.
REQ-022 On the 16th rising SCLK edge the block SHALL, in the same CLK edge:
- enter QUIET with CS=1 and SCLK=1;
- load DATA1/DATA2 from shift bits [11:0];
- pulse VALID;
- set FRAME_ERR = OR of bits [15:12] of both shift registers.
REQ-023 VALID latency SHALL be 1+32*CLK_DIV CLK cycles after START is sampled.
- Default CLK_DIV=4 gives 129 cycles.
REQ-024 QUIET SHALL last exactly QUIET_CYCLES cycles.
- Exit -> CONV if CONTINUOUS=1 or START=1, else IDLE.
REQ-025 START while BUSY SHALL be ignored; it is not queued.
REQ-026 CONTINUOUS deasserted mid-frame SHALL let the current frame complete normally.
REQ-027 DATA1/DATA2/FRAME_ERR SHALL change only on VALID.
REQ-028 SCLK and CS SHALL be registered outputs and glitch-free.

Reset
REQ-029 RST_N low SHALL asynchronously force:
- state IDLE;
- CS=1, SCLK=1, BUSY=0, VALID=0, FRAME_ERR=0;
- DATA1=DATA2=0;
- all counters and shift registers cleared.
REQ-030 Reset mid-frame SHALL abort with no VALID.
- CS SHALL rise immediately (asynchronously).
REQ-031 After RST_N rises, the first conversion SHALL start only on START or CONTINUOUS.

Structure
REQ-032 A shared package ad1_pkg SHALL hold:
- the FSM state type;
- SAMPLE_W=12, FRAME_BITS=16, LEAD_BITS=4.
REQ-033 The SCLK divider and edge-strobe generator SHALL be sub-module ad1_sclk_gen.
- Inputs: enable, clear.
- Outputs: SCLK, rise/fall strobes.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Single frame: CLK_DIV=4, START pulse, converter model sends 0x0ABC / 0x0123 -> VALID at cycle 129; DATA1=0xABC; DATA2=0x123; FRAME_ERR=0; CS low for 128 cycles; exactly 16 SCLK falls.
- Continuous: CONTINUOUS=1, QUIET_CYCLES=8, samples 0x001,0x002,0x003 -> three VALIDs spaced 129+8 cycles; CS high exactly 8 cycles between frames.
- Frame error: channel 2 sends 0x8FFF -> DATA2=0xFFF; FRAME_ERR=1; next clean frame clears FRAME_ERR.
- START while BUSY: extra START pulses at cycles 10 and 60 -> exactly one VALID; returns to IDLE.
- Reset mid-frame: RST_N low at cycle 70 -> CS=1, SCLK=1 immediately; no VALID; DATA1=DATA2=0; a new START gives a correct frame.
- Boundary divider: CLK_DIV=2, sample 0xFFF -> VALID at cycle 65; DATA1=0xFFF.
